// File: rtl/seq_booth_multiplier.sv
// seq_booth_multiplier
//   Iterative radix-2 Booth signed multiplier. The unit takes two W-bit
//   two's-complement operands on a start pulse. It retires one Booth step
//   per clock and returns the low W bits of the product with an overflow flag.
//
//   Optional build macro: MULT_ZERO_SKIP_EN
//     When defined, a start with a zero operand goes straight to DONE with a
//     zero result. This gives a one-cycle latency, and busy never rises.
//
//   Ports:
//     clk        rising-edge clock
//     clr        asynchronous active-low reset
//     ctrl_start start request; the unit ignores it while RUN is active
//     data_a     multiplicand (signed), sampled with ctrl_start
//     data_b     multiplier (signed), sampled with ctrl_start
//     result     low W bits of the product, held until the next completion
//     overflow   product not representable in W signed bits
//     data_ready one-cycle completion pulse
//     busy       high while in RUN
module seq_booth_multiplier #(
    parameter int W     = 32,
    parameter int CNT_W = 6
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         ctrl_start,
    input  logic [W-1:0] data_a,
    input  logic [W-1:0] data_b,
    output logic [W-1:0] result,
    output logic         overflow,
    output logic         data_ready,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [W:0]       m;      // sign-extended multiplicand
    logic [2*W+1:0]   p;      // {acc[W:0], multiplier[W-1:0], booth bit}
    logic [CNT_W-1:0] cnt;

    logic [W:0]       acc;
    logic [W:0]       acc_next;
    logic [2*W+1:0]   p_next;
    logic             last_step;
    logic             ovf_next;
    logic             skip;

`ifdef MULT_ZERO_SKIP_EN
    assign skip = (data_a == '0) || (data_b == '0);
`else
    assign skip = 1'b0;
`endif

    // One Booth step: add or subtract M on the accumulator, then shift the
    // whole register right arithmetically. With a W+1-bit accumulator, the
    // most negative operand needs no special case.
    always_comb begin
        acc = p[2*W+1:W+1];
        case (p[1:0])
            2'b01:   acc_next = acc + m;
            2'b10:   acc_next = acc - m;
            default: acc_next = acc;
        endcase
        p_next    = {acc_next[W], acc_next, p[W:1]};
        last_step = (cnt == CNT_W'(W - 1));
        // Product bits [2W-1:W-1] sit at p_next[2W:W]. They must all match
        // the sign for the product to fit in W bits.
        ovf_next  = !((p_next[2*W:W] == '0) || (p_next[2*W:W] == '1));
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state      <= IDLE;
            m          <= '0;
            p          <= '0;
            cnt        <= '0;
            result     <= '0;
            overflow   <= 1'b0;
            data_ready <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_ready <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (ctrl_start) begin
                        if (skip) begin
                            state      <= DONE;
                            result     <= '0;
                            overflow   <= 1'b0;
                            data_ready <= 1'b1;
                        end else begin
                            m     <= {data_a[W-1], data_a};
                            p     <= {{(W+1){1'b0}}, data_b, 1'b0};
                            cnt   <= '0;
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    p   <= p_next;
                    cnt <= cnt + 1'b1;
                    if (last_step) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        data_ready <= 1'b1;
                        result     <= p_next[W:1];
                        overflow   <= ovf_next;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
